// File: rtl/led_row_pkg.sv
// Shared types and constants for the UART row-load decoder: FSM states,
// the row-load command byte and the default geometry of a framebuffer row.
package led_row_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROW,
        ST_PIXEL,
        ST_DISCARD
    } row_dec_state_t;

    localparam logic [7:0] CMD_ROW_LOAD = 8'h4C;

    localparam int DEF_PIXEL_WIDTH     = 64;
    localparam int DEF_PIXEL_HEIGHT    = 32;
    localparam int DEF_BYTES_PER_PIXEL = 2;
    localparam int DEF_ROW_BYTES       = DEF_PIXEL_WIDTH * DEF_BYTES_PER_PIXEL;
    localparam int DEF_ADDR_W          = $clog2(DEF_PIXEL_HEIGHT) + $clog2(DEF_PIXEL_WIDTH);

    // Framebuffer address is {row, column}.
    function automatic int addr_w(input int width, input int height);
        return $clog2(height) + $clog2(width);
    endfunction

endpackage

// File: rtl/uart_row_decoder_if.sv
// Byte-in / pixel-write-out bundle of the row decoder. The master side feeds
// UART bytes and consumes framebuffer writes; the slave side is the decoder.
interface uart_row_decoder_if #(
    parameter int PIXEL_WIDTH     = led_row_pkg::DEF_PIXEL_WIDTH,
    parameter int PIXEL_HEIGHT    = led_row_pkg::DEF_PIXEL_HEIGHT,
    parameter int BYTES_PER_PIXEL = led_row_pkg::DEF_BYTES_PER_PIXEL
);
    localparam int ADDR_W = led_row_pkg::addr_w(PIXEL_WIDTH, PIXEL_HEIGHT);
    localparam int WORD_W = 8 * BYTES_PER_PIXEL;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              row_done;
    logic              busy;
    logic              err_pulse;

    modport master (
        output rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, row_done, busy, err_pulse
    );

    modport slave (
        input  rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, row_done, busy, err_pulse
    );

endinterface

// File: rtl/uart_row_decoder.sv
// Turns the UART byte stream "L <row> <pixel bytes...>" into one framebuffer
// write per pixel. Define ROW_DECODER_TIMEOUT_EN to abort rows stalled too long.
module uart_row_decoder
    import led_row_pkg::*;
#(
    parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
    parameter int PIXEL_HEIGHT    = DEF_PIXEL_HEIGHT,
    parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
    parameter int TIMEOUT_TICKS   = 2000
) (
    input  logic                clk_in,
    input  logic                reset_n,
    uart_row_decoder_if.slave   bus
);

    localparam int ROW_W     = $clog2(PIXEL_HEIGHT);
    localparam int COL_W     = $clog2(PIXEL_WIDTH);
    localparam int BYTE_W    = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int ROW_BYTES = PIXEL_WIDTH * BYTES_PER_PIXEL;
    localparam int DISC_W    = $clog2(ROW_BYTES);
    localparam int WORD_W    = 8 * BYTES_PER_PIXEL;

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(PIXEL_WIDTH - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_PIXEL - 1);
    localparam logic [DISC_W-1:0] LAST_DISC = DISC_W'(ROW_BYTES - 1);

    row_dec_state_t          state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic [DISC_W-1:0]       disc_q, disc_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic [WORD_W+7:0]       shifted;
    logic                    wr_en_q, wr_en_d;
    logic                    row_done_q, row_done_d;
    logic                    err_q, err_d;
    logic [ROW_W+COL_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]       wr_data_q, wr_data_d;

`ifdef ROW_DECODER_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    logic [IDLE_W-1:0]       idle_q, idle_d;
`endif

    always_comb begin
        // NOTE: every next-state value gets a default before any branch, so no path infers a latch.
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        byte_d     = byte_q;
        disc_d     = disc_q;
        shift_d    = shift_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        row_done_d = 1'b0;
        err_d      = 1'b0;
        shifted    = {shift_q, bus.rx_data};

        if (bus.rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == CMD_ROW_LOAD) state_d = ST_ROW;
                end
                ST_ROW: begin
                    if (int'(bus.rx_data) < PIXEL_HEIGHT) begin
                        row_d   = ROW_W'(bus.rx_data);
                        col_d   = '0;
                        byte_d  = '0;
                        state_d = ST_PIXEL;
                    end else begin
                        err_d   = 1'b1;
                        disc_d  = '0;
                        state_d = ST_DISCARD;
                    end
                end
                ST_PIXEL: begin
                    shift_d = shifted[WORD_W-1:0];
                    if (byte_q == LAST_BYTE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {row_q, col_q};
                        wr_data_d = shift_d;
                        byte_d    = '0;
                        col_d     = col_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            row_done_d = 1'b1;
                            col_d      = '0;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
                ST_DISCARD: begin
                    // A bad row still carries a full payload; swallow it so it is not parsed as commands.
                    if (disc_q == LAST_DISC) begin
                        disc_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        disc_d = disc_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef ROW_DECODER_TIMEOUT_EN
        idle_d = '0;
        if (state_q != ST_IDLE && !bus.rx_valid) begin
            if (idle_q == IDLE_W'(TIMEOUT_TICKS - 1)) begin
                state_d = ST_IDLE;
                col_d   = '0;
                byte_d  = '0;
                disc_d  = '0;
                err_d   = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the pixel shift register is a handful of flops, not a memory, so it is reset with the rest.
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            byte_q     <= '0;
            disc_q     <= '0;
            shift_q    <= '0;
            wr_en_q    <= 1'b0;
            row_done_q <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every register here sees pre-edge values of the others.
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            byte_q     <= byte_d;
            disc_q     <= disc_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            row_done_q <= row_done_d;
            err_q      <= err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef ROW_DECODER_TIMEOUT_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`endif

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.row_done  = row_done_q;
    assign bus.err_pulse = err_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_row_decoder.sv
// Directed bench for uart_row_decoder: drives row-load byte streams and checks
// every framebuffer write against a scoreboard of expected address/data/cycle.
`timescale 1ns/1ps
module tb_uart_row_decoder;
    import led_row_pkg::*;

    localparam int PW        = 64;
    localparam int PH        = 32;
    localparam int BPP       = 2;
    localparam int TT        = 50;
    localparam int ROW_BYTES = PW * BPP;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } exp_t;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_in = ~clk_in;

    uart_row_decoder_if #(.PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .BYTES_PER_PIXEL(BPP)) bus ();

    uart_row_decoder #(
        .PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .BYTES_PER_PIXEL(BPP), .TIMEOUT_TICKS(TT)
    ) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .bus    (bus)
    );

    exp_t       sb[$];
    exp_t       e;
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         done_count = 0;
    int         err_count  = 0;
    logic [7:0] hi_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Output monitor: every write must match the oldest scoreboard entry.
    always @(negedge clk_in) begin
        if (bus.err_pulse) err_count++;
        if (bus.row_done)  done_count++;
        if (bus.wr_en) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", 32'(bus.wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr",  32'(bus.wr_addr),  32'(e.addr));
                check("wr_data",  32'(bus.wr_data),  32'(e.data));
                check("row_done", 32'(bus.row_done), 32'(e.done));
                check("wr_cycle", 32'(cyc),          32'(e.cyc));
            end
        end
    end

    function automatic logic [7:0] pix_byte(input int seed, input int k);
        logic [7:0] head [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h98, 8'h00};
        if (seed == 0 && k < 6) return head[k];
        if (seed == 3)          return CMD_ROW_LOAD;
        if (k % 17 == 5)        return CMD_ROW_LOAD;
        return 8'(k * 37 + seed * 11 + 1);
    endfunction

    // Drive one byte for one cycle, then idle for gap cycles (gap < 0: random 0..3).
    task automatic send(input logic [7:0] b, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk_in); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (g) begin @(posedge clk_in); #1; end
    endtask

    task automatic send_header(input logic [7:0] idx, input int gap);
        send(CMD_ROW_LOAD, gap);
        check("busy_after_L", 32'(bus.busy), 32'd1);
        send(idx, gap);
    endtask

    task automatic send_pixels(input logic [7:0] idx, input int k_from, input int k_to,
                               input int seed, input int gap);
        exp_t x;
        logic [7:0] b;
        for (int k = k_from; k < k_to; k++) begin
            b = pix_byte(seed, k);
            if (k % 2 == 0) begin
                hi_byte = b;
            end else if (int'(idx) < PH) begin
                x.addr = {idx[4:0], 6'(k / 2)};
                x.data = {hi_byte, b};
                x.done = (k == ROW_BYTES - 1);
                x.cyc  = cyc + 1;
                sb.push_back(x);
            end
            send(b, gap);
        end
    endtask

    task automatic settle(input string tag, input int exp_done, input int exp_err);
        repeat (3) begin @(posedge clk_in); #1; end
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_count), 32'(exp_done));
        check({tag, "_err_cnt"},  32'(err_count),  32'(exp_err));
        check({tag, "_busy"},     32'(bus.busy),   32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"},     32'(bus.wr_en),     32'd0);
        check({tag, "_wr_addr"},   32'(bus.wr_addr),   32'd0);
        check({tag, "_wr_data"},   32'(bus.wr_data),   32'd0);
        check({tag, "_row_done"},  32'(bus.row_done),  32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_err_pulse"}, 32'(bus.err_pulse), 32'd0);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset_n      = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(posedge clk_in); #1;

        // Row 4 with the documented leading pixels 0x0000, 0x0000, 0x9800.
        send_header(8'd4, 1);
        send_pixels(8'd4, 0, ROW_BYTES, 0, 1);
        settle("row4", 1, 0);

        // Bytes of other commands are ignored while idle.
        send(8'h62, 0); send(8'h72, 1); send(8'h52, 0); send(8'h20, 2); send(8'h2D, 0);
        check("other_cmds_busy", 32'(bus.busy), 32'd0);
        send_header(8'd5, -1);
        send_pixels(8'd5, 0, ROW_BYTES, 1, -1);
        settle("row5", 2, 0);

        // Out-of-range row: one error, payload (all 0x4C) discarded.
        send_header(8'd32, 1);
        check("bad_row_busy", 32'(bus.busy), 32'd1);
        send_pixels(8'd32, 0, ROW_BYTES, 3, 0);
        settle("bad_row", 2, 1);

        // Row 1 at full rate: one write every two cycles.
        send_header(8'd1, 0);
        send_pixels(8'd1, 0, ROW_BYTES, 4, 0);
        settle("row1_fast", 3, 1);

        // Reset mid-row clears outputs asynchronously.
        send_header(8'd2, 1);
        send_pixels(8'd2, 0, 10, 5, 1);
        check("mid_row_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #2;
        check_outputs_zero("async_reset");
        @(posedge clk_in); #1;
        reset_n = 1'b1;
        @(posedge clk_in); #1;
        send_header(8'd2, 0);
        send_pixels(8'd2, 0, ROW_BYTES, 6, 0);
        settle("row2", 4, 1);

        // Truncated row followed by a long idle gap.
        send_header(8'd3, 1);
        send_pixels(8'd3, 0, 3, 7, 1);
        repeat (60) begin @(posedge clk_in); #1; end
`ifdef ROW_DECODER_TIMEOUT_EN
        settle("timeout", 4, 2);
        send_header(8'd6, 1);
        send_pixels(8'd6, 0, ROW_BYTES, 8, 1);
        settle("row6", 5, 2);
`else
        check("stall_busy", 32'(bus.busy), 32'd1);
        check("stall_err",  32'(err_count), 32'd1);
        send_pixels(8'd3, 3, ROW_BYTES, 7, 1);
        settle("row3", 5, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
